line_window_3x3_gen: RTL and testbench

- Upstream window generator for 3x3 neighbourhood filters (mean, median, Sobel) in the grey-level image pipeline.
- Buffers two previous lines of Y pixels in a single on-chip RAM and emits a 3x3 window for every input pixel.
- Delays the frame sync signals so they stay aligned with the window.
- Handles top and left borders by zero masking, so downstream stages need no border logic.

---
 rtl/img_pkg.sv | 19 +
 rtl/line_ram_sdp.sv | 30 +++
 rtl/line_window_3x3_gen.sv | 197 +++++++++++++++++++
 tb/tb_line_window_3x3_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the grey-level image pipeline.
package img_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned IMG_WIDTH_DEF = 640;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  // Smallest address width able to index 'value' entries (minimum 1 bit).
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'(1) << width) < 64'(value)) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/line_ram_sdp.sv
// Simple dual-port line RAM with registered read; no reset so it maps onto block RAM.
module line_ram_sdp #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_window_3x3_gen.sv
// 3x3 window generator: two buffered lines in one RAM, zero-masked top/left borders,
// window and frame syncs both delayed by exactly two cycles.
module line_window_3x3_gen
  import img_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int unsigned COL_W     = clog2_f(IMG_WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pre_frame_vsync,
  input  logic              pre_frame_hsync,
  input  logic              pre_frame_valid,
  input  logic [DATA_W-1:0] pre_img_y,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_hsync,
  output logic              matrix_frame_valid,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33,
  output logic              line_ovf
);

  localparam int unsigned ROW_W  = 2;
  localparam int unsigned WORD_W = 2 * DATA_W;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = '1;

  logic              vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
  logic              hs_d1_q, hs_d1_d, hs_d2_q, hs_d2_d;
  logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic              line_full_q, line_full_d;
  logic              line_has_pix_q, line_has_pix_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_ovf_q, s1_ovf_d;
  logic [DATA_W-1:0] s1_pix_q, s1_pix_d;
  logic [COL_W-1:0]  s1_col_q, s1_col_d;
  logic [ROW_W-1:0]  s1_row_q, s1_row_d;
  logic              out_vld_q, out_vld_d;
  // win[row][col]: row 0 is the oldest line, col 2 is the newest column.
  logic [2:0][2:0][DATA_W-1:0] win_q, win_d;

  logic              pix_vld_c, vs_rise_c, hs_fall_c, ovf_c;
  logic [DATA_W-1:0] rd_row_m1_c, rd_row_m2_c, row_m1_c, row_m2_c;
  logic              ram_wr_en_c;
  logic [WORD_W-1:0] ram_wr_data_c;
  logic [WORD_W-1:0] ram_rd_data;

  line_ram_sdp #(
    .WIDTH (WORD_W),
    .DEPTH (IMG_WIDTH),
    .ADDR_W(COL_W)
  ) u_line_ram (
    .clk    (clk),
    .wr_en  (ram_wr_en_c),
    .wr_addr(s1_col_q),
    .wr_data(ram_wr_data_c),
    .rd_en  (pix_vld_c),
    .rd_addr(col_cnt_q),
    .rd_data(ram_rd_data)
  );

  always_comb begin
    pix_vld_c = pre_frame_valid & pre_frame_hsync;
    vs_rise_c = pre_frame_vsync & ~vs_d1_q;
    hs_fall_c = ~pre_frame_hsync & hs_d1_q;
    ovf_c     = pix_vld_c & line_full_q;

    vs_d1_d = pre_frame_vsync;
    vs_d2_d = vs_d1_q;
    hs_d1_d = pre_frame_hsync;
    hs_d2_d = hs_d1_q;

    col_cnt_d      = col_cnt_q;
    row_cnt_d      = row_cnt_q;
    line_full_d    = line_full_q;
    line_has_pix_d = line_has_pix_q;

    // Frame start beats line end when both edges land in the same cycle.
    if (vs_rise_c) begin
      col_cnt_d      = '0;
      row_cnt_d      = '0;
      line_full_d    = 1'b0;
      line_has_pix_d = 1'b0;
    end else if (hs_fall_c) begin
      col_cnt_d      = '0;
      line_full_d    = 1'b0;
      line_has_pix_d = 1'b0;
      if (line_has_pix_q && (row_cnt_q != ROW_MAX)) begin
        row_cnt_d = row_cnt_q + ROW_W'(1);
      end
    end else if (pix_vld_c) begin
      line_has_pix_d = 1'b1;
      if (col_cnt_q == COL_MAX) begin
        line_full_d = 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + COL_W'(1);
      end
    end

    s1_vld_d = pix_vld_c;
    s1_ovf_d = ovf_c;
    s1_pix_d = pre_img_y;
    s1_col_d = col_cnt_q;
    s1_row_d = row_cnt_q;

    // Upper rows are hidden on the first two lines of a frame and for overflow pixels.
    rd_row_m1_c = ram_rd_data[DATA_W-1:0];
    rd_row_m2_c = ram_rd_data[WORD_W-1:DATA_W];
    row_m1_c    = (s1_ovf_q || (s1_row_q == '0)) ? '0 : rd_row_m1_c;
    row_m2_c    = (s1_ovf_q || (s1_row_q <= ROW_W'(1))) ? '0 : rd_row_m2_c;

    ram_wr_en_c   = s1_vld_q & ~s1_ovf_q;
    ram_wr_data_c = {rd_row_m1_c, s1_pix_q};

    out_vld_d = s1_vld_q;
    win_d     = win_q;
    if (s1_vld_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = row_m2_c;
      win_d[1][2] = row_m1_c;
      win_d[2][2] = s1_pix_q;
      if (s1_col_q == '0) begin
        for (int r = 0; r < 3; r++) begin
          win_d[r][0] = '0;
          win_d[r][1] = '0;
        end
      end else if (s1_col_q == COL_W'(1)) begin
        for (int r = 0; r < 3; r++) begin
          win_d[r][0] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1_q        <= 1'b0;
      vs_d2_q        <= 1'b0;
      hs_d1_q        <= 1'b0;
      hs_d2_q        <= 1'b0;
      col_cnt_q      <= '0;
      row_cnt_q      <= '0;
      line_full_q    <= 1'b0;
      line_has_pix_q <= 1'b0;
      s1_vld_q       <= 1'b0;
      s1_ovf_q       <= 1'b0;
      s1_pix_q       <= '0;
      s1_col_q       <= '0;
      s1_row_q       <= '0;
      out_vld_q      <= 1'b0;
      win_q          <= '0;
    end else begin
      vs_d1_q        <= vs_d1_d;
      vs_d2_q        <= vs_d2_d;
      hs_d1_q        <= hs_d1_d;
      hs_d2_q        <= hs_d2_d;
      col_cnt_q      <= col_cnt_d;
      row_cnt_q      <= row_cnt_d;
      line_full_q    <= line_full_d;
      line_has_pix_q <= line_has_pix_d;
      s1_vld_q       <= s1_vld_d;
      s1_ovf_q       <= s1_ovf_d;
      s1_pix_q       <= s1_pix_d;
      s1_col_q       <= s1_col_d;
      s1_row_q       <= s1_row_d;
      out_vld_q      <= out_vld_d;
      win_q          <= win_d;
    end
  end

  assign matrix_frame_vsync = vs_d2_q;
  assign matrix_frame_hsync = hs_d2_q;
  assign matrix_frame_valid = out_vld_q;
  assign line_ovf           = s1_ovf_q;
  assign matrix_p11 = win_q[0][0];
  assign matrix_p12 = win_q[0][1];
  assign matrix_p13 = win_q[0][2];
  assign matrix_p21 = win_q[1][0];
  assign matrix_p22 = win_q[1][1];
  assign matrix_p23 = win_q[1][2];
  assign matrix_p31 = win_q[2][0];
  assign matrix_p32 = win_q[2][1];
  assign matrix_p33 = win_q[2][2];

endmodule

// File: tb/tb_line_window_3x3_gen.sv
// Directed bench for line_window_3x3_gen on a 4x4 frame with pixel = 16*row + col.
module tb_line_window_3x3_gen;
  import img_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pre_frame_vsync = 1'b0;
  logic          pre_frame_hsync = 1'b0;
  logic          pre_frame_valid = 1'b0;
  logic [DW-1:0] pre_img_y = '0;
  logic          matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid;
  logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;
  logic          line_ovf;

  int tests_run = 0;
  int tests_failed = 0;
  logic vs_lvl = 1'b0;
  logic [71:0] win_log[$];
  int rd_ptr = 0;
  int ovf_cnt = 0;
  int ovf_idx = -1;

  line_window_3x3_gen #(.DATA_W(DW), .IMG_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
    .pre_frame_valid(pre_frame_valid), .pre_img_y(pre_img_y),
    .matrix_frame_vsync(matrix_frame_vsync), .matrix_frame_hsync(matrix_frame_hsync),
    .matrix_frame_valid(matrix_frame_valid),
    .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
    .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
    .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
    .line_ovf(line_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] cur_win();
    return {matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
            matrix_p31, matrix_p32, matrix_p33};
  endfunction

  always @(negedge clk) begin
    if (matrix_frame_valid) win_log.push_back(cur_win());
    if (line_ovf) begin
      ovf_cnt = ovf_cnt + 1;
      ovf_idx = win_log.size();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic pixel_t px(input int rr, input int cc);
    if (rr < 0 || cc < 0) return '0;
    return 8'(16 * rr + cc);
  endfunction

  // Reference window for the pixel at (r, c): taps outside the frame are zero.
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[71 - 8*(3*i + j) -: 8] = px(r - 2 + i, c - 2 + j);
    return w;
  endfunction

  task automatic tick(input logic hs, input logic vld, input logic [DW-1:0] y);
    @(posedge clk);
    #1;
    pre_frame_vsync = vs_lvl;
    pre_frame_hsync = hs;
    pre_frame_valid = vld;
    pre_img_y       = y;
  endtask

  task automatic start_frame();
    vs_lvl = 1'b0;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    vs_lvl = 1'b1;
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic drive_line(input int r, input int n, input int gap);
    for (int c = 0; c < n; c++) begin
      tick(1'b1, 1'b1, 8'(16 * r + c));
      for (int g = 0; g < gap; g++) tick(1'b1, 1'b0, 8'hEE);
    end
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, '0);
    tests_run++;
    if ({matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid, line_ovf, cur_win()} !== 76'd0) begin
      tests_failed++;
      $display("FAIL reset_state got win=%h v=%b h=%b vld=%b ovf=%b expected all zero",
               cur_win(), matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid, line_ovf);
    end
  endtask

  task automatic test_latency();
    vs_lvl = 1'b0;
    tick(1'b0, 1'b0, '0);
    vs_lvl = 1'b1;
    tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b1, 8'h00);
    tests_run++;
    if (matrix_frame_vsync !== 1'b0) begin
      tests_failed++; $display("FAIL vsync_delay_early got %b expected 0", matrix_frame_vsync);
    end
    tick(1'b1, 1'b0, '0);
    tests_run++;
    if ({matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL latency_t1 got vs/hs/vld=%b%b%b expected 100",
               matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid);
    end
    tick(1'b1, 1'b0, '0);
    tests_run++;
    if ({matrix_frame_hsync, matrix_frame_valid} !== 2'b11 || cur_win() !== 72'd0) begin
      tests_failed++;
      $display("FAIL latency_t2 got hs=%b vld=%b win=%h expected hs=1 vld=1 win=0",
               matrix_frame_hsync, matrix_frame_valid, cur_win());
    end
    tick(1'b1, 1'b1, 8'h01);
    tick(1'b1, 1'b1, 8'h02);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tests_run++;
    if (cur_win() !== 72'h00_00_00_00_00_00_00_01_02 || matrix_frame_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL row0_col2 got %h vld=%b expected 000000000000000102 vld=1", cur_win(), matrix_frame_valid);
    end
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, '0);
    rd_ptr = win_log.size();
  endtask

  task automatic test_full_frame();
    logic [71:0] w[16];
    start_frame();
    for (int r = 0; r < 4; r++) drive_line(r, 4, 0);
    for (int i = 0; i < 16; i++) begin
      w[i] = 'x;
      tests_run++;
      if (rd_ptr >= win_log.size()) begin
        tests_failed++; $display("FAIL frame_win[%0d] got no window expected %h", i, exp_win(i/4, i%4));
      end else begin
        w[i] = win_log[rd_ptr]; rd_ptr++;
        if (w[i] !== exp_win(i/4, i%4)) begin
          tests_failed++; $display("FAIL frame_win[%0d] got %h expected %h", i, w[i], exp_win(i/4, i%4));
        end
      end
    end
    tests_run++;
    if (w[10] !== 72'h00_01_02_10_11_12_20_21_22) begin
      tests_failed++; $display("FAIL row2_col2 got %h expected 000102101112202122", w[10]);
    end
    tests_run++;
    if (w[4] !== 72'h00_00_00_00_00_00_00_00_10) begin
      tests_failed++; $display("FAIL row1_col0 got %h expected 000000000000000010", w[4]);
    end
  endtask

  task automatic test_gaps_second_frame();
    logic [71:0] got;
    start_frame();
    for (int r = 0; r < 4; r++) drive_line(r, 4, 2);
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (rd_ptr >= win_log.size()) begin
        tests_failed++; $display("FAIL gap_win[%0d] got no window expected %h", i, exp_win(i/4, i%4));
      end else begin
        got = win_log[rd_ptr]; rd_ptr++;
        if (got !== exp_win(i/4, i%4)) begin
          tests_failed++; $display("FAIL gap_win[%0d] got %h expected %h", i, got, exp_win(i/4, i%4));
        end
      end
    end
    tests_run++;
    if (win_log.size() != rd_ptr) begin
      tests_failed++; $display("FAIL gap_extra_windows got %0d expected 0", win_log.size() - rd_ptr);
    end
    tests_run++;
    if (cur_win() !== exp_win(3, 3)) begin
      tests_failed++; $display("FAIL gap_hold got %h expected %h", cur_win(), exp_win(3, 3));
    end
    rd_ptr = win_log.size();
  endtask

  task automatic test_overflow();
    logic [71:0] got;
    int ovf_base, ptr_base;
    start_frame();
    ovf_base = ovf_cnt;
    ptr_base = rd_ptr;
    drive_line(0, 5, 0);
    drive_line(1, 4, 0);
    tests_run++;
    if (ovf_cnt - ovf_base != 1 || ovf_idx - ptr_base != 4) begin
      tests_failed++;
      $display("FAIL ovf_pulse got count=%0d at_win=%0d expected count=1 at_win=4",
               ovf_cnt - ovf_base, ovf_idx - ptr_base);
    end
    for (int i = 0; i < 9; i++) begin
      int r, c;
      r = (i < 5) ? 0 : 1;
      c = (i < 5) ? i : i - 5;
      tests_run++;
      if (rd_ptr >= win_log.size()) begin
        tests_failed++; $display("FAIL ovf_win[%0d] got no window expected %h", i, exp_win(r, c));
      end else begin
        got = win_log[rd_ptr]; rd_ptr++;
        if (got !== exp_win(r, c)) begin
          tests_failed++; $display("FAIL ovf_win[%0d] got %h expected %h", i, got, exp_win(r, c));
        end else if (i == 4 && (got[71:24] !== 48'd0 || got[7:0] !== 8'h04)) begin
          tests_failed++; $display("FAIL ovf_fifth got %h expected upper rows 0 p33=04", got);
        end else if (i == 8 && got[31:24] !== 8'h03) begin
          tests_failed++; $display("FAIL ovf_next_row_p23 got %h expected 03", got[31:24]);
        end
      end
    end
    rd_ptr = win_log.size();
  endtask

  task automatic test_vsync_wins();
    logic [71:0] got;
    vs_lvl = 1'b0;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    for (int c = 0; c < 4; c++) tick(1'b1, 1'b1, 8'(8'h30 + c));
    vs_lvl = 1'b1;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    rd_ptr = win_log.size();
    drive_line(0, 4, 0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_ptr >= win_log.size()) begin
        tests_failed++; $display("FAIL vs_wins_win[%0d] got no window expected %h", i, exp_win(0, i));
      end else begin
        got = win_log[rd_ptr]; rd_ptr++;
        if (got !== exp_win(0, i)) begin
          tests_failed++; $display("FAIL vs_wins_win[%0d] got %h expected %h", i, got, exp_win(0, i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] got;
    start_frame();
    tick(1'b1, 1'b1, 8'h00);
    tick(1'b1, 1'b1, 8'h01);
    tick(1'b1, 1'b1, 8'h02);
    tests_run++;
    if (matrix_frame_valid !== 1'b1) begin
      tests_failed++; $display("FAIL pre_reset_valid got %b expected 1", matrix_frame_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid, line_ovf, cur_win()} !== 76'd0) begin
      tests_failed++;
      $display("FAIL reset_mid got win=%h v=%b h=%b vld=%b ovf=%b expected all zero",
               cur_win(), matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid, line_ovf);
    end
    vs_lvl = 1'b0;
    pre_frame_vsync = 1'b0; pre_frame_hsync = 1'b0; pre_frame_valid = 1'b0; pre_img_y = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_ptr = win_log.size();
    start_frame();
    drive_line(0, 4, 0);
    drive_line(1, 4, 0);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rd_ptr >= win_log.size()) begin
        tests_failed++; $display("FAIL post_reset_win[%0d] got no window expected %h", i, exp_win(i/4, i%4));
      end else begin
        got = win_log[rd_ptr]; rd_ptr++;
        if (got !== exp_win(i/4, i%4)) begin
          tests_failed++; $display("FAIL post_reset_win[%0d] got %h expected %h", i, got, exp_win(i/4, i%4));
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_latency();
    test_full_frame();
    test_gaps_second_frame();
    test_overflow();
    test_vsync_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
